wb_gpio_initiator: RTL and testbench

Wishbone initiator that issues single read/write transactions to the user-area GPIO register block (io_l/io_h/oeb_l/oeb_h words at 0x300FFFF0/F4/EC/E8) and to any other user-area responder. It takes one command at a time over a valid/ready interface, drives a classic single-beat Wishbone cycle, and waits for the responder's ack or for a timeout. It then returns read data and an error flag over a valid/ready response interface. It lets user logic or a test sequencer exercise the GPIO responder without the management core.

---
 rtl/wb_gpio_initiator_pkg.sv | 18 +
 rtl/wb_gpio_initiator_if.sv | 40 ++++
 rtl/wb_gpio_initiator_ack_timer.sv | 39 +++
 rtl/wb_gpio_initiator.sv | 134 +++++++++++++
 tb/tb_wb_gpio_initiator.sv | 327 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/wb_gpio_initiator_pkg.sv
// Shared types and constants for the Wishbone GPIO initiator.
// The GPIO register map is shared with benches and firmware models.
package wb_gpio_initiator_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUS  = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam int TIMER_WIDTH = 8;

    localparam logic [31:0] GPIO_IO_L  = 32'h300F_FFF0;
    localparam logic [31:0] GPIO_IO_H  = 32'h300F_FFF4;
    localparam logic [31:0] GPIO_OEB_L = 32'h300F_FFEC;
    localparam logic [31:0] GPIO_OEB_H = 32'h300F_FFE8;

endpackage

// File: rtl/wb_gpio_initiator_if.sv
// Command/response channel plus Wishbone initiator bus.
// The master modport is the initiator; slave is the user logic and responder side.
interface wb_gpio_initiator_if;

    logic        cmd_valid;
    logic        cmd_ready;
    logic        cmd_we;
    logic [31:0] cmd_adr;
    logic [31:0] cmd_dat;
    logic [3:0]  cmd_sel;

    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_dat;
    logic        rsp_err;

    logic        wbm_cyc_o;
    logic        wbm_stb_o;
    logic        wbm_we_o;
    logic [3:0]  wbm_sel_o;
    logic [31:0] wbm_adr_o;
    logic [31:0] wbm_dat_o;
    logic        wbm_ack_i;
    logic [31:0] wbm_dat_i;

    modport master (
        input  cmd_valid, cmd_we, cmd_adr, cmd_dat, cmd_sel, rsp_ready,
        input  wbm_ack_i, wbm_dat_i,
        output cmd_ready, rsp_valid, rsp_dat, rsp_err,
        output wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_sel_o, wbm_adr_o, wbm_dat_o
    );

    modport slave (
        output cmd_valid, cmd_we, cmd_adr, cmd_dat, cmd_sel, rsp_ready,
        output wbm_ack_i, wbm_dat_i,
        input  cmd_ready, rsp_valid, rsp_dat, rsp_err,
        input  wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_sel_o, wbm_adr_o, wbm_dat_o
    );

endinterface

// File: rtl/wb_gpio_initiator_ack_timer.sv
// Ack timeout counter: counts cycles a strobe waits for ack.
// expired_o flags the last cycle the initiator is willing to wait.
module wb_ack_timer
    import wb_gpio_initiator_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic clear_i,
    input  logic enable_i,
    output logic expired_o
);

    localparam logic [TIMER_WIDTH-1:0] LAST_COUNT = TIMER_WIDTH'(TIMEOUT_CYCLES - 1);

    logic [TIMER_WIDTH-1:0] count_q;
    logic [TIMER_WIDTH-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (clear_i) begin
            count_d = '0;
        end else if (enable_i) begin
            count_d = count_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign expired_o = (count_q == LAST_COUNT);

endmodule

// File: rtl/wb_gpio_initiator.sv
// Single-beat Wishbone initiator driven by a valid/ready command channel,
// returning read data or a timeout error on a valid/ready response channel.
module wb_gpio_initiator
    import wb_gpio_initiator_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                 wb_clk_i,
    input  logic                 wb_rst_i,
    wb_gpio_initiator_if.master  bus
);

    state_t      state_q,    state_d;
    logic        cyc_q,      cyc_d;
    logic        stb_q,      stb_d;
    logic        we_q,       we_d;
    logic [3:0]  sel_q,      sel_d;
    logic [31:0] adr_q,      adr_d;
    logic [31:0] dat_q,      dat_d;
    logic        rspValid_q, rspValid_d;
    logic        rspErr_q,   rspErr_d;
    logic [31:0] rspDat_q,   rspDat_d;

    logic timerClear;
    logic timerEnable;
    logic timerExpired;

    wb_ack_timer #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) ackTimer (
        .clk_i     (wb_clk_i),
        .rst_i     (wb_rst_i),
        .clear_i   (timerClear),
        .enable_i  (timerEnable),
        .expired_o (timerExpired)
    );

    always_comb begin
        state_d     = state_q;
        cyc_d       = cyc_q;
        stb_d       = stb_q;
        we_d        = we_q;
        sel_d       = sel_q;
        adr_d       = adr_q;
        dat_d       = dat_q;
        rspValid_d  = rspValid_q;
        rspErr_d    = rspErr_q;
        rspDat_d    = rspDat_q;
        timerClear  = 1'b0;
        timerEnable = 1'b0;

        case (state_q)
            IDLE: begin
                if (bus.cmd_valid) begin
                    we_d       = bus.cmd_we;
                    adr_d      = bus.cmd_adr;
                    dat_d      = bus.cmd_dat;
                    sel_d      = bus.cmd_sel;
                    cyc_d      = 1'b1;
                    stb_d      = 1'b1;
                    timerClear = 1'b1;
                    state_d    = BUS;
                end
            end
            BUS: begin
                // Ack is checked first so it wins over a timeout on the same edge.
                if (bus.wbm_ack_i || timerExpired) begin
                    cyc_d      = 1'b0;
                    stb_d      = 1'b0;
                    we_d       = 1'b0;
                    sel_d      = '0;
                    adr_d      = '0;
                    dat_d      = '0;
                    rspValid_d = 1'b1;
                    rspErr_d   = !bus.wbm_ack_i;
                    rspDat_d   = (bus.wbm_ack_i && !we_q) ? bus.wbm_dat_i : '0;
                    state_d    = RESP;
                end else begin
                    timerEnable = 1'b1;
                end
            end
            RESP: begin
                if (bus.rsp_ready) begin
                    rspValid_d = 1'b0;
                    rspErr_d   = 1'b0;
                    rspDat_d   = '0;
                    state_d    = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            state_q    <= IDLE;
            cyc_q      <= 1'b0;
            stb_q      <= 1'b0;
            we_q       <= 1'b0;
            sel_q      <= '0;
            adr_q      <= '0;
            dat_q      <= '0;
            rspValid_q <= 1'b0;
            rspErr_q   <= 1'b0;
            rspDat_q   <= '0;
        end else begin
            state_q    <= state_d;
            cyc_q      <= cyc_d;
            stb_q      <= stb_d;
            we_q       <= we_d;
            sel_q      <= sel_d;
            adr_q      <= adr_d;
            dat_q      <= dat_d;
            rspValid_q <= rspValid_d;
            rspErr_q   <= rspErr_d;
            rspDat_q   <= rspDat_d;
        end
    end

    // Reset is the only input reaching cmd_ready, so it reads 0 while reset is held.
    assign bus.cmd_ready = (state_q == IDLE) && !wb_rst_i;
    assign bus.rsp_valid = rspValid_q;
    assign bus.rsp_err   = rspErr_q;
    assign bus.rsp_dat   = rspDat_q;
    assign bus.wbm_cyc_o = cyc_q;
    assign bus.wbm_stb_o = stb_q;
    assign bus.wbm_we_o  = we_q;
    assign bus.wbm_sel_o = sel_q;
    assign bus.wbm_adr_o = adr_q;
    assign bus.wbm_dat_o = dat_q;

endmodule

// File: tb/tb_wb_gpio_initiator.sv
// Scoreboard bench for wb_gpio_initiator against a GPIO register responder model
// that acks one cycle after seeing a strobe to one of its four registers.
module tb_wb_gpio_initiator;
    import wb_gpio_initiator_pkg::*;

    typedef struct packed {
        logic [31:0] dat;
        logic        err;
    } rspExp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    wb_gpio_initiator_if bus ();

    wb_gpio_initiator #(
        .TIMEOUT_CYCLES (16)
    ) dut (
        .wb_clk_i (clk),
        .wb_rst_i (rst),
        .bus      (bus)
    );

    int compared   = 0;
    int mismatched = 0;

    rspExp_t expQ[$];
    rspExp_t monExp;

    int cycleCnt = 0;
    always @(posedge clk) cycleCnt++;

    // GPIO responder model
    logic [31:0] ioL, ioH, oebL, oebH, gpioDat;
    logic        gpioAck;
    logic        injectAck = 1'b0;

    function automatic logic gpioHit(logic [31:0] adr);
        return (adr == GPIO_IO_L) || (adr == GPIO_IO_H) ||
               (adr == GPIO_OEB_L) || (adr == GPIO_OEB_H);
    endfunction

    function automatic logic [31:0] mergeBytes(logic [31:0] oldV, logic [31:0] newV, logic [3:0] sel);
        logic [31:0] r;
        r = oldV;
        for (int b = 0; b < 4; b++) if (sel[b]) r[8*b +: 8] = newV[8*b +: 8];
        return r;
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            gpioAck <= 1'b0;
            gpioDat <= '0;
            ioL     <= '0;
            ioH     <= '0;
            oebL    <= '0;
            oebH    <= '0;
        end else begin
            gpioAck <= 1'b0;
            if (bus.wbm_cyc_o && bus.wbm_stb_o && !gpioAck && gpioHit(bus.wbm_adr_o)) begin
                gpioAck <= 1'b1;
                if (bus.wbm_we_o) begin
                    case (bus.wbm_adr_o)
                        GPIO_IO_L:  ioL  <= mergeBytes(ioL,  bus.wbm_dat_o, bus.wbm_sel_o);
                        GPIO_IO_H:  ioH  <= mergeBytes(ioH,  bus.wbm_dat_o, bus.wbm_sel_o);
                        GPIO_OEB_L: oebL <= mergeBytes(oebL, bus.wbm_dat_o, bus.wbm_sel_o);
                        default:    oebH <= mergeBytes(oebH, bus.wbm_dat_o, bus.wbm_sel_o);
                    endcase
                end else begin
                    case (bus.wbm_adr_o)
                        GPIO_IO_L:  gpioDat <= ioL;
                        GPIO_IO_H:  gpioDat <= ioH;
                        GPIO_OEB_L: gpioDat <= oebL;
                        default:    gpioDat <= oebH;
                    endcase
                end
            end
        end
    end

    assign bus.wbm_ack_i = gpioAck | injectAck;
    assign bus.wbm_dat_i = gpioDat;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        compared++;
        if (actual !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
        end
    endtask

    // Bus/response monitor and scoreboard consumer
    logic prevStb = 1'b0, prevRsp = 1'b0;
    int   stbRun = 0, stbRiseCount = 0, rspRises = 0;
    int   lastRiseCycle = 0, rspRiseCycle = 0, lastConsumeCycle = 0;
    logic [1:0] busAtRspRise = 2'b00;
    int   riseQ[$];
    int   widthQ[$];

    always @(negedge clk) begin
        if (rst) begin
            prevStb = 1'b0;
            prevRsp = 1'b0;
            stbRun  = 0;
        end else begin
            if (bus.wbm_stb_o) begin
                if (!prevStb) begin
                    stbRiseCount++;
                    lastRiseCycle = cycleCnt;
                    riseQ.push_back(cycleCnt);
                end
                stbRun++;
            end else if (prevStb) begin
                widthQ.push_back(stbRun);
                stbRun = 0;
            end
            prevStb = bus.wbm_stb_o;

            if (bus.rsp_valid && !prevRsp) begin
                rspRises++;
                rspRiseCycle = cycleCnt;
                busAtRspRise = {bus.wbm_cyc_o, bus.wbm_stb_o};
            end
            prevRsp = bus.rsp_valid;

            if (bus.rsp_valid && bus.rsp_ready) begin
                lastConsumeCycle = cycleCnt + 1;
                if (expQ.size() == 0) begin
                    compared++;
                    mismatched++;
                    $display("[TB] FAIL unexpectedRsp: got dat 0x%08h err %0d, expected no response",
                             bus.rsp_dat, bus.rsp_err);
                end else begin
                    monExp = expQ.pop_front();
                    checkOutput("rspDat", bus.rsp_dat, monExp.dat);
                    checkOutput("rspErr", 32'(bus.rsp_err), 32'(monExp.err));
                end
            end
        end
    end

    task automatic startCmd(input logic we, input logic [31:0] adr, input logic [31:0] dat,
                            input logic [3:0] sel, input logic [31:0] expDat, input logic expErr);
        bus.cmd_we    = we;
        bus.cmd_adr   = adr;
        bus.cmd_dat   = dat;
        bus.cmd_sel   = sel;
        bus.cmd_valid = 1'b1;
        expQ.push_back('{dat: expDat, err: expErr});
    endtask

    task automatic waitAccept();
        int  start;
        bit  seen;
        start = stbRiseCount;
        seen  = 1'b0;
        for (int i = 0; i < 100 && !seen; i++) begin
            @(posedge clk);
            #2;
            if (stbRiseCount != start) seen = 1'b1;
        end
        if (!seen) begin
            compared++;
            mismatched++;
            $display("[TB] FAIL acceptTimeout: got no strobe, expected command acceptance");
        end
    endtask

    task automatic applyStimulus(input logic we, input logic [31:0] adr, input logic [31:0] dat,
                                 input logic [3:0] sel, input logic [31:0] expDat, input logic expErr);
        startCmd(we, adr, dat, sel, expDat, expErr);
        waitAccept();
        bus.cmd_valid = 1'b0;
    endtask

    task automatic waitIdle();
        bit done;
        done = 1'b0;
        for (int i = 0; i < 200 && !done; i++) begin
            @(posedge clk);
            #2;
            if (expQ.size() == 0 && !bus.rsp_valid && bus.cmd_ready) done = 1'b1;
        end
        if (!done) begin
            compared++;
            mismatched++;
            $display("[TB] FAIL idleTimeout: got %0d pending responses, expected 0", expQ.size());
        end
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got no completion, expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int rspBefore;
        bus.cmd_valid = 1'b0;
        bus.cmd_we    = 1'b0;
        bus.cmd_adr   = '0;
        bus.cmd_dat   = '0;
        bus.cmd_sel   = '0;
        bus.rsp_ready = 1'b1;

        #2;
        checkOutput("cmdReadyInReset", 32'(bus.cmd_ready), 32'd0);
        checkOutput("cycInReset",      32'(bus.wbm_cyc_o), 32'd0);
        checkOutput("rspValidInReset", 32'(bus.rsp_valid), 32'd0);
        #10 rst = 1'b0;
        @(negedge clk);
        checkOutput("cmdReadyAfterRst", 32'(bus.cmd_ready), 32'd1);
        checkOutput("rspDatAfterRst",   bus.rsp_dat,          32'd0);
        checkOutput("adrAfterRst",      bus.wbm_adr_o,        32'd0);

        $display("[TB] write IO_L");
        applyStimulus(1'b1, GPIO_IO_L, 32'hA5A5_0F0F, 4'hF, 32'h0, 1'b0);
        waitIdle();
        checkOutput("writeLatency",  32'(rspRiseCycle - lastRiseCycle), 32'd2);
        checkOutput("writeStbWidth", 32'(widthQ[$]), 32'd2);
        checkOutput("ioL",           ioL, 32'hA5A5_0F0F);

        $display("[TB] write then read OEB_L");
        applyStimulus(1'b1, GPIO_OEB_L, 32'h0000_00FF, 4'hF, 32'h0, 1'b0);
        waitIdle();
        applyStimulus(1'b0, GPIO_OEB_L, 32'h0, 4'hF, 32'h0000_00FF, 1'b0);
        waitIdle();

        $display("[TB] read unmapped address");
        applyStimulus(1'b0, 32'h3000_0000, 32'h0, 4'hF, 32'h0, 1'b1);
        waitIdle();
        checkOutput("timeoutStbWidth", 32'(widthQ[$]), 32'd16);
        checkOutput("timeoutLatency",  32'(rspRiseCycle - lastRiseCycle), 32'd16);
        checkOutput("timeoutBusIdle",  32'(busAtRspRise), 32'd0);

        $display("[TB] response backpressure");
        bus.rsp_ready = 1'b0;
        startCmd(1'b0, GPIO_IO_L, 32'h0, 4'hF, 32'hA5A5_0F0F, 1'b0);
        waitAccept();
        startCmd(1'b1, GPIO_IO_H, 32'h1234_5678, 4'hF, 32'h0, 1'b0);
        for (int i = 0; i < 50 && !bus.rsp_valid; i++) begin
            @(posedge clk);
            #2;
        end
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checkOutput("holdRspValid", 32'(bus.rsp_valid), 32'd1);
            checkOutput("holdRspDat",   bus.rsp_dat,          32'hA5A5_0F0F);
            checkOutput("holdCmdReady", 32'(bus.cmd_ready), 32'd0);
            injectAck = (i == 1);
        end
        @(posedge clk);
        #1 bus.rsp_ready = 1'b1;
        waitAccept();
        bus.cmd_valid = 1'b0;
        checkOutput("acceptAfterConsume", 32'(lastRiseCycle - lastConsumeCycle), 32'd1);
        waitIdle();
        checkOutput("ioH", ioH, 32'h1234_5678);

        $display("[TB] back-to-back writes");
        riseQ.delete();
        widthQ.delete();
        startCmd(1'b1, GPIO_IO_H, 32'h0F0F_0F0F, 4'hF, 32'h0, 1'b0);
        expQ.push_back('{dat: 32'h0, err: 1'b0});
        expQ.push_back('{dat: 32'h0, err: 1'b0});
        waitAccept();
        waitAccept();
        waitAccept();
        bus.cmd_valid = 1'b0;
        waitIdle();
        checkOutput("b2bCount", 32'(riseQ.size()), 32'd3);
        if (riseQ.size() == 3 && widthQ.size() == 3) begin
            checkOutput("b2bPeriod1", 32'(riseQ[1] - riseQ[0]), 32'd4);
            checkOutput("b2bPeriod2", 32'(riseQ[2] - riseQ[1]), 32'd4);
            for (int i = 0; i < 3; i++) checkOutput("b2bWidth", 32'(widthQ[i]), 32'd2);
        end

        $display("[TB] ack while idle");
        rspBefore = rspRises;
        @(posedge clk);
        #1 injectAck = 1'b1;
        @(posedge clk);
        #1 injectAck = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checkOutput("idleAckRsp",      32'(rspRises - rspBefore), 32'd0);
        checkOutput("idleAckCyc",      32'(bus.wbm_cyc_o), 32'd0);
        checkOutput("idleAckCmdReady", 32'(bus.cmd_ready), 32'd1);

        $display("[TB] reset mid-transaction");
        rspBefore = rspRises;
        startCmd(1'b1, 32'h3000_0000, 32'hDEAD_BEEF, 4'hA, 32'h0, 1'b0);
        void'(expQ.pop_back());
        waitAccept();
        bus.cmd_valid = 1'b0;
        repeat (2) @(posedge clk);
        #3 rst = 1'b1;
        #1;
        checkOutput("rstCyc",      32'(bus.wbm_cyc_o), 32'd0);
        checkOutput("rstStb",      32'(bus.wbm_stb_o), 32'd0);
        checkOutput("rstWe",       32'(bus.wbm_we_o),  32'd0);
        checkOutput("rstSel",      32'(bus.wbm_sel_o), 32'd0);
        checkOutput("rstAdr",      bus.wbm_adr_o,        32'd0);
        checkOutput("rstDat",      bus.wbm_dat_o,        32'd0);
        checkOutput("rstRspValid", 32'(bus.rsp_valid), 32'd0);
        checkOutput("rstCmdReady", 32'(bus.cmd_ready), 32'd0);
        @(negedge clk);
        #2 rst = 1'b0;
        @(posedge clk);
        #2;
        checkOutput("postRstCmdReady", 32'(bus.cmd_ready), 32'd1);
        repeat (25) @(posedge clk);
        #2;
        checkOutput("postRstNoRsp", 32'(rspRises - rspBefore), 32'd0);
        checkOutput("postRstStb",   32'(bus.wbm_stb_o), 32'd0);

        $display("[TB] read after reset");
        applyStimulus(1'b0, GPIO_IO_L, 32'h0, 4'hF, 32'h0, 1'b0);
        waitIdle();
        checkOutput("scoreboardEmpty", 32'(expQ.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
